// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide, big-endian byte memory: handles LB/LBU/LH/LHU/LW/SB/SH/SW.
// Build option: define LSU_ALIGN_CHECK_EN to report misaligned accesses as errors instead of force-aligning them.
module mem_lsu #(
   parameter int MEMSIZE = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic        mem_read,
   output logic [31:0] mem_raddr,
   input  logic [31:0] mem_rdata,
   output logic        mem_write,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LD     = 3'd1;
   localparam logic [2:0] RMW_RD = 3'd2;
   localparam logic [2:0] WR     = 3'd3;
   localparam logic [2:0] RESP   = 3'd4;

   localparam logic [31:0] LAST_BASE = 32'(MEMSIZE - 4);

   logic [2:0]  state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] word_q, word_d;
   logic [31:0] result_q, result_d;
   logic        err_q, err_d;

   logic        opLegal, opHalf, opWord, misaligned, outOfRange, reqErr;
   logic [31:0] reqBase, reqAddrFixed;
   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadValue, mergedWord, base;

   always_comb begin
      opLegal = 1'b0;
      case (req_op)
         4'b0000, 4'b0001, 4'b0011, 4'b0100,
         4'b0101, 4'b1000, 4'b1001, 4'b1011: opLegal = 1'b1;
         default:                            opLegal = 1'b0;
      endcase
   end

   assign opHalf     = (req_op[1:0] == 2'b01);
   assign opWord     = (req_op[1:0] == 2'b11);
   assign misaligned = (opHalf & req_addr[0]) | (opWord & (|req_addr[1:0]));
   assign reqBase    = {req_addr[31:2], 2'b00};
   assign outOfRange = (reqBase > LAST_BASE);

`ifdef LSU_ALIGN_CHECK_EN
   assign reqErr       = ~opLegal | misaligned | outOfRange;
   assign reqAddrFixed = req_addr;
`else
   // Misalignment is not an error here: the low address bits are dropped to the natural boundary.
   assign reqErr       = ~opLegal | outOfRange;
   assign reqAddrFixed = opWord ? reqBase :
                         opHalf ? {req_addr[31:1], 1'b0} : req_addr;
`endif

   assign base = {addr_q[31:2], 2'b00};

   always_comb begin
      loadByte = 8'h00;
      case (addr_q[1:0])
         2'd0:    loadByte = mem_rdata[31:24];
         2'd1:    loadByte = mem_rdata[23:16];
         2'd2:    loadByte = mem_rdata[15:8];
         default: loadByte = mem_rdata[7:0];
      endcase
   end

   assign loadHalf = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

   // op_q[2] marks the unsigned loads; op_q[1:0] gives the access size.
   always_comb begin
      loadValue = mem_rdata;
      case (op_q[1:0])
         2'b00:   loadValue = op_q[2] ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
         2'b01:   loadValue = op_q[2] ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
         default: loadValue = mem_rdata;
      endcase
   end

   always_comb begin
      mergedWord = mem_rdata;
      if (op_q[1:0] == 2'b01) begin
         if (addr_q[1]) mergedWord = {mem_rdata[31:16], wdata_q[15:0]};
         else           mergedWord = {wdata_q[15:0], mem_rdata[15:0]};
      end else begin
         case (addr_q[1:0])
            2'd0:    mergedWord = {wdata_q[7:0], mem_rdata[23:0]};
            2'd1:    mergedWord = {mem_rdata[31:24], wdata_q[7:0], mem_rdata[15:0]};
            2'd2:    mergedWord = {mem_rdata[31:16], wdata_q[7:0], mem_rdata[7:0]};
            default: mergedWord = {mem_rdata[31:8], wdata_q[7:0]};
         endcase
      end
   end

   // Erroneous requests skip straight to RESP so the memory never sees a strobe for them.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      word_d   = word_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d     = req_op;
               addr_d   = reqAddrFixed;
               wdata_d  = req_wdata;
               result_d = 32'h0;
               err_d    = reqErr;
               if (reqErr)          state_d = RESP;
               else if (!req_op[3]) state_d = LD;
               else if (opWord)     state_d = WR;
               else                 state_d = RMW_RD;
            end
         end
         LD: begin
            result_d = loadValue;
            state_d  = RESP;
         end
         RMW_RD: begin
            word_d  = mergedWord;
            state_d = WR;
         end
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= 4'h0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         word_q   <= 32'h0;
         result_q <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         word_q   <= word_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_data  = resp_valid ? result_q : 32'h0;
   assign resp_err   = resp_valid & err_q;

   assign mem_read   = (state_q == LD) || (state_q == RMW_RD);
   assign mem_raddr  = mem_read ? base : 32'h0;
   assign mem_write  = (state_q == WR);
   assign mem_waddr  = mem_write ? base : 32'h0;
   assign mem_wdata  = !mem_write ? 32'h0 :
                       (op_q[1:0] == 2'b11) ? wdata_q : word_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a big-endian byte-array memory model attached.
module tb_mem_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        mem_read;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        mem_write;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;

   int checks = 0;
   int errors = 0;

   logic [7:0] memBytes [0:1023];

   logic [31:0] obsData;
   logic        obsErr;
   int          obsCycles;
   int          obsReads;
   int          obsWrites;
   logic [31:0] obsRaddr;
   logic [31:0] obsWaddr;
   logic [31:0] obsWdata;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0011;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LHU = 4'b0101;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SH  = 4'b1001;
   localparam logic [3:0] OP_SW  = 4'b1011;

   mem_lsu #(.MEMSIZE(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .mem_read   (mem_read),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .mem_write  (mem_write),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] wordAt(input logic [31:0] a);
      int idx;
      idx = int'(a[9:0]) & ~3;
      return {memBytes[idx], memBytes[idx + 1], memBytes[idx + 2], memBytes[idx + 3]};
   endfunction

   // Combinational big-endian read port; writes land on the rising edge, like the real array.
   always_comb mem_rdata = wordAt(mem_raddr);

   always @(posedge clk) begin
      if (mem_write) begin
         memBytes[(int'(mem_waddr[9:0]) & ~3)]     <= mem_wdata[31:24];
         memBytes[(int'(mem_waddr[9:0]) & ~3) + 1] <= mem_wdata[23:16];
         memBytes[(int'(mem_waddr[9:0]) & ~3) + 2] <= mem_wdata[15:8];
         memBytes[(int'(mem_waddr[9:0]) & ~3) + 3] <= mem_wdata[7:0];
      end
   end

   // Issues one request and records what the memory port saw until the response pulse.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata);
      int waitCount;
      obsData   = 32'hx;
      obsErr    = 1'bx;
      obsCycles = 0;
      obsReads  = 0;
      obsWrites = 0;
      obsRaddr  = 32'h0;
      obsWaddr  = 32'h0;
      obsWdata  = 32'h0;
      waitCount = 0;
      @(negedge clk);
      while (!req_ready && waitCount < 10) begin
         @(negedge clk);
         waitCount++;
      end
      if (!req_ready) begin
         $display("[TB] FAIL ready_timeout: req_ready=%b required 1", req_ready);
         errors++;
         return;
      end
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      obsCycles = 1;
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 4'h0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      while (!resp_valid && obsCycles < 10) begin
         if (mem_read) begin
            obsReads++;
            obsRaddr = mem_raddr;
         end
         if (mem_write) begin
            obsWrites++;
            obsWaddr = mem_waddr;
            obsWdata = mem_wdata;
         end
         @(posedge clk);
         obsCycles++;
         @(negedge clk);
      end
      if (!resp_valid) begin
         $display("[TB] FAIL resp_timeout: op=%h addr=%h no resp_valid after %0d cycles", op, addr, obsCycles);
         errors++;
      end
      obsData = resp_data;
      obsErr  = resp_err;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 4'h0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
         $display("[TB] FAIL reset_resp: ready=%b valid=%b data=%h err=%b required 1 0 0 0",
                  req_ready, resp_valid, resp_data, resp_err);
         errors++;
      end
      checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_raddr !== 32'h0 ||
          mem_waddr !== 32'h0 || mem_wdata !== 32'h0) begin
         $display("[TB] FAIL reset_mem: rd=%b wr=%b raddr=%h waddr=%h wdata=%h required all 0",
                  mem_read, mem_write, mem_raddr, mem_waddr, mem_wdata);
         errors++;
      end
      rst = 1'b0;
   endtask

   task automatic test_store_word();
      applyStimulus(OP_SW, 32'h10, 32'hDEADBEEF);
      checks++;
      if (obsCycles !== 2 || obsErr !== 1'b0 || obsData !== 32'h0) begin
         $display("[TB] FAIL sw_resp: cycles=%0d err=%b data=%h required 2 0 00000000", obsCycles, obsErr, obsData);
         errors++;
      end
      checks++;
      if (obsReads !== 0 || obsWrites !== 1 || obsWaddr !== 32'h10 || obsWdata !== 32'hDEADBEEF) begin
         $display("[TB] FAIL sw_port: reads=%0d writes=%0d waddr=%h wdata=%h required 0 1 00000010 deadbeef",
                  obsReads, obsWrites, obsWaddr, obsWdata);
         errors++;
      end
      applyStimulus(OP_LW, 32'h10, 32'h0);
      checks++;
      if (obsData !== 32'hDEADBEEF || obsErr !== 1'b0 || obsCycles !== 2 || obsReads !== 1 || obsWrites !== 0) begin
         $display("[TB] FAIL lw_after_sw: data=%h err=%b cycles=%0d reads=%0d writes=%0d required deadbeef 0 2 1 0",
                  obsData, obsErr, obsCycles, obsReads, obsWrites);
         errors++;
      end
   endtask

   task automatic test_loads();
      logic [3:0]  ops  [6] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LB, OP_LBU};
      logic [31:0] adrs [6] = '{32'h10, 32'h13, 32'h12, 32'h10, 32'h11, 32'h12};
      logic [31:0] exps [6] = '{32'hFFFFFFDE, 32'h000000EF, 32'hFFFFBEEF, 32'h0000DEAD, 32'hFFFFFFAD, 32'h000000BE};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(ops[i], adrs[i], 32'h0);
         checks++;
         if (obsData !== exps[i] || obsErr !== 1'b0 || obsRaddr !== 32'h10) begin
            $display("[TB] FAIL load_%0d: op=%h addr=%h data=%h err=%b raddr=%h required %h 0 00000010",
                     i, ops[i], adrs[i], obsData, obsErr, obsRaddr, exps[i]);
            errors++;
         end
      end
   endtask

   task automatic test_sub_word_stores();
      applyStimulus(OP_SB, 32'h11, 32'h00000012);
      checks++;
      if (obsCycles !== 3 || obsErr !== 1'b0 || obsData !== 32'h0 || obsReads !== 1 || obsWrites !== 1 ||
          obsRaddr !== 32'h10 || obsWdata !== 32'hDE12BEEF) begin
         $display("[TB] FAIL sb_rmw: cycles=%0d err=%b data=%h reads=%0d writes=%0d raddr=%h wdata=%h required 3 0 0 1 1 00000010 de12beef",
                  obsCycles, obsErr, obsData, obsReads, obsWrites, obsRaddr, obsWdata);
         errors++;
      end
      applyStimulus(OP_LW, 32'h10, 32'h0);
      checks++;
      if (obsData !== 32'hDE12BEEF) begin
         $display("[TB] FAIL lw_after_sb: data=%h required de12beef", obsData);
         errors++;
      end
      applyStimulus(OP_SH, 32'h12, 32'h00001234);
      checks++;
      if (obsWdata !== 32'hDE121234 || wordAt(32'h10) !== 32'hDE121234) begin
         $display("[TB] FAIL sh_low: wdata=%h mem=%h required de121234", obsWdata, wordAt(32'h10));
         errors++;
      end
      applyStimulus(OP_SH, 32'h10, 32'hFFFFABCD);
      checks++;
      if (obsWdata !== 32'hABCD1234) begin
         $display("[TB] FAIL sh_high: wdata=%h required abcd1234", obsWdata);
         errors++;
      end
      applyStimulus(OP_SB, 32'h13, 32'hAAAAAA77);
      checks++;
      if (obsWdata !== 32'hABCD1277 || wordAt(32'h10) !== 32'hABCD1277) begin
         $display("[TB] FAIL sb_last: wdata=%h mem=%h required abcd1277", obsWdata, wordAt(32'h10));
         errors++;
      end
   endtask

   task automatic test_alignment();
`ifdef LSU_ALIGN_CHECK_EN
      applyStimulus(OP_LW, 32'h12, 32'h0);
      checks++;
      if (obsErr !== 1'b1 || obsData !== 32'h0 || obsCycles !== 1 || obsReads !== 0 || obsWrites !== 0) begin
         $display("[TB] FAIL lw_misaligned: err=%b data=%h cycles=%0d reads=%0d writes=%0d required 1 0 1 0 0",
                  obsErr, obsData, obsCycles, obsReads, obsWrites);
         errors++;
      end
      applyStimulus(OP_SH, 32'h11, 32'h5555);
      checks++;
      if (obsErr !== 1'b1 || obsWrites !== 0 || wordAt(32'h10) !== 32'hABCD1277) begin
         $display("[TB] FAIL sh_misaligned: err=%b writes=%0d mem=%h required 1 0 abcd1277",
                  obsErr, obsWrites, wordAt(32'h10));
         errors++;
      end
`else
      applyStimulus(OP_LW, 32'h12, 32'h0);
      checks++;
      if (obsErr !== 1'b0 || obsData !== 32'hABCD1277 || obsRaddr !== 32'h10) begin
         $display("[TB] FAIL lw_forced_align: err=%b data=%h raddr=%h required 0 abcd1277 00000010",
                  obsErr, obsData, obsRaddr);
         errors++;
      end
      applyStimulus(OP_LH, 32'h11, 32'h0);
      checks++;
      if (obsErr !== 1'b0 || obsData !== 32'hFFFFABCD) begin
         $display("[TB] FAIL lh_forced_align: err=%b data=%h required 0 ffffabcd", obsErr, obsData);
         errors++;
      end
`endif
   endtask

   task automatic test_range();
      applyStimulus(OP_LW, 32'h3FC, 32'h0);
      checks++;
      if (obsErr !== 1'b0 || obsData !== 32'h0 || obsReads !== 1 || obsRaddr !== 32'h3FC) begin
         $display("[TB] FAIL lw_last_word: err=%b data=%h reads=%0d raddr=%h required 0 0 1 000003fc",
                  obsErr, obsData, obsReads, obsRaddr);
         errors++;
      end
      applyStimulus(OP_LW, 32'h400, 32'h0);
      checks++;
      if (obsErr !== 1'b1 || obsData !== 32'h0 || obsCycles !== 1 || obsReads !== 0 || obsWrites !== 0) begin
         $display("[TB] FAIL lw_out_of_range: err=%b data=%h cycles=%0d reads=%0d writes=%0d required 1 0 1 0 0",
                  obsErr, obsData, obsCycles, obsReads, obsWrites);
         errors++;
      end
      applyStimulus(4'b0010, 32'h10, 32'h0);
      checks++;
      if (obsErr !== 1'b1 || obsReads !== 0 || obsWrites !== 0) begin
         $display("[TB] FAIL illegal_op: err=%b reads=%0d writes=%0d required 1 0 0", obsErr, obsReads, obsWrites);
         errors++;
      end
      applyStimulus(OP_SB, 32'hFFFFFFFC, 32'h99);
      checks++;
      if (obsErr !== 1'b1 || obsReads !== 0 || obsWrites !== 0) begin
         $display("[TB] FAIL sb_high_addr: err=%b reads=%0d writes=%0d required 1 0 0", obsErr, obsReads, obsWrites);
         errors++;
      end
      applyStimulus(OP_LBU, 32'h3FF, 32'h0);
      checks++;
      if (obsErr !== 1'b0 || obsData !== 32'h0 || obsRaddr !== 32'h3FC) begin
         $display("[TB] FAIL lbu_last_byte: err=%b data=%h raddr=%h required 0 0 000003fc", obsErr, obsData, obsRaddr);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      applyStimulus(OP_LHU, 32'h12, 32'h0);
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || obsData !== 32'h00001277) begin
         $display("[TB] FAIL resp_one_cycle: valid=%b ready=%b data=%h required 0 1 00001277",
                  resp_valid, req_ready, obsData);
         errors++;
      end
   endtask

   task automatic test_reset_mid_op();
      int strayEvents;
      strayEvents = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_SB;
      req_addr  = 32'h20;
      req_wdata = 32'h55;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (mem_read !== 1'b1 || mem_raddr !== 32'h20) begin
         $display("[TB] FAIL rmw_read_phase: rd=%b raddr=%h required 1 00000020", mem_read, mem_raddr);
         errors++;
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || mem_write !== 1'b0 || resp_valid !== 1'b0) begin
         $display("[TB] FAIL reset_mid_op: ready=%b wr=%b valid=%b required 1 0 0", req_ready, mem_write, resp_valid);
         errors++;
      end
      for (int i = 0; i < 4; i++) begin
         if (resp_valid || mem_write) strayEvents++;
         @(negedge clk);
      end
      checks++;
      if (strayEvents !== 0 || wordAt(32'h20) !== 32'h0) begin
         $display("[TB] FAIL dropped_op: stray=%0d mem=%h required 0 00000000", strayEvents, wordAt(32'h20));
         errors++;
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) memBytes[i] = 8'h00;
      test_reset();
      test_store_word();
      test_loads();
      test_sub_word_stores();
      test_alignment();
      test_range();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
